// File: rtl/uart_io_if.sv
// uart_io_if: IO bus bundle (address, read/write strobes, write data in; combinational read data out)
interface uart_io_if;
  logic [31:0] io_address;
  logic        io_read_en;
  logic        io_write_en;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  modport master(output io_address, io_read_en, io_write_en, io_write_data, input io_read_data);
  modport slave(input io_address, io_read_en, io_write_en, io_write_data, output io_read_data);
endinterface

// File: rtl/uart_io.sv
// uart_io: 8N1 UART on the IO bus (bus: status/rx data/tx data registers; uart_tx serial out, uart_rx serial in)
module uart_io #(
  parameter logic [31:0] BASE_ADDRESS = 32'h18,
  parameter int BAUD_DIVIDE = 27,
  parameter int FIFO_LENGTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  uart_io_if.slave bus,
  output logic    uart_tx,
  input  logic    uart_rx
);
  localparam int CW = $clog2(BAUD_DIVIDE + 1);
  localparam int AW = $clog2(FIFO_LENGTH);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  tx_state_t tx_state, tx_state_n;
  rx_state_t rx_state, rx_state_n;
  logic [CW-1:0] div_cnt;
  logic [3:0] tx_ticks, tx_ticks_n, rx_ticks, rx_ticks_n;
  logic [2:0] tx_bits, tx_bits_n, rx_bits, rx_bits_n;
  logic [7:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic tx_pend, tx_pend_n, uart_tx_n, rx_s1, rx_s2;
  logic [7:0] mem [FIFO_LENGTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic tick, tx_end, overrun, frame_err, rd_stat, rd_rx, wr_tx, tx_ready, rx_ready;
  logic push, pop, full, push_ok, frame_bad, unused;
  assign tick = div_cnt == CW'(BAUD_DIVIDE - 1);
  assign tx_end = tick && tx_ticks == 4'd15;
  assign rd_stat = bus.io_read_en && bus.io_address == BASE_ADDRESS;
  assign rd_rx = bus.io_read_en && bus.io_address == BASE_ADDRESS + 32'd4;
  assign wr_tx = bus.io_write_en && bus.io_address == BASE_ADDRESS + 32'd8;
  // an accepted byte waiting for the next tick already counts as busy
  assign tx_ready = tx_state == TX_IDLE && !tx_pend;
  assign rx_ready = cnt != '0;
  assign full = cnt == (AW+1)'(FIFO_LENGTH);
  assign pop = rd_rx && rx_ready;
  assign push_ok = push && (!full || pop);
  assign unused = &{1'b0, bus.io_write_data[31:8]};
  assign bus.io_read_data = bus.io_address == BASE_ADDRESS ? {28'd0, frame_err, overrun, tx_ready, rx_ready} :
                            bus.io_address == BASE_ADDRESS + 32'd4 && rx_ready ? {24'd0, mem[rp]} : 32'd0;
  always_comb begin
    tx_state_n = tx_state;
    tx_ticks_n = tick ? tx_ticks + 4'd1 : tx_ticks;
    tx_bits_n = tx_bits;
    tx_shift_n = wr_tx && tx_ready ? bus.io_write_data[7:0] : tx_shift;
    tx_pend_n = tx_pend || (wr_tx && tx_ready);
    uart_tx_n = uart_tx;
    case (tx_state)
      TX_IDLE: if (tx_pend_n && tick) begin
        tx_state_n = TX_START;
        tx_pend_n = 1'b0;
        tx_ticks_n = '0;
        uart_tx_n = 1'b0;
      end
      TX_START: if (tx_end) begin
        tx_state_n = TX_DATA;
        tx_bits_n = '0;
        uart_tx_n = tx_shift[0];
      end
      TX_DATA: if (tx_end) begin
        tx_state_n = tx_bits == 3'd7 ? TX_STOP : TX_DATA;
        tx_bits_n = tx_bits + 3'd1;
        tx_shift_n = tx_shift >> 1;
        uart_tx_n = tx_bits == 3'd7 ? 1'b1 : tx_shift[1];
      end
      default: if (tx_end) begin
        tx_state_n = TX_IDLE;
        uart_tx_n = 1'b1;
      end
    endcase
  end
  always_comb begin
    rx_state_n = rx_state;
    rx_ticks_n = tick ? rx_ticks + 4'd1 : rx_ticks;
    rx_bits_n = rx_bits;
    rx_shift_n = rx_shift;
    push = 1'b0;
    frame_bad = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_s2) begin
        rx_state_n = RX_START;
        rx_ticks_n = '0;
      end
      RX_START: if (tick && rx_ticks == 4'd7) begin
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        rx_ticks_n = '0;
        rx_bits_n = '0;
      end
      RX_DATA: if (tick && rx_ticks == 4'd15) begin
        rx_state_n = rx_bits == 3'd7 ? RX_STOP : RX_DATA;
        rx_bits_n = rx_bits + 3'd1;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
      end
      default: if (tick && rx_ticks == 4'd15) begin
        rx_state_n = RX_IDLE;
        push = rx_s2;
        frame_bad = !rx_s2;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tx_state <= TX_IDLE;
      tx_ticks <= '0;
      tx_bits <= '0;
      tx_shift <= '0;
      tx_pend <= 1'b0;
      uart_tx <= 1'b1;
      rx_state <= RX_IDLE;
      rx_ticks <= '0;
      rx_bits <= '0;
      rx_shift <= '0;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      tx_state <= tx_state_n;
      tx_ticks <= tx_ticks_n;
      tx_bits <= tx_bits_n;
      tx_shift <= tx_shift_n;
      tx_pend <= tx_pend_n;
      uart_tx <= uart_tx_n;
      rx_state <= rx_state_n;
      rx_ticks <= rx_ticks_n;
      rx_bits <= rx_bits_n;
      rx_shift <= rx_shift_n;
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      wp <= push_ok ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
      // a new event in the same cycle as a status read must survive the clear
      overrun <= (push && !push_ok) || (overrun && !rd_stat);
      frame_err <= frame_bad || (frame_err && !rd_stat);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= rx_shift;
  end
endmodule

// File: tb/tb_uart_io.sv
// tb_uart_io: randomized self-checking bench for uart_io against a queue-based reference model
module tb_uart_io;
  localparam logic [31:0] ST_A = 32'h18, RX_A = 32'h1c, TX_A = 32'h20;
  localparam int FL = 8;
  logic clk = 1'b0, reset = 1'b1, uart_tx, uart_rx = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  logic [7:0] q[$];
  bit m_ovr = 1'b0, m_fe = 1'b0;
  uart_io_if bus();
  uart_io #(.BASE_ADDRESS(32'h18), .BAUD_DIVIDE(2), .FIFO_LENGTH(FL)) dut (
    .clk(clk), .reset(reset), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.io_address = a;
    bus.io_read_en = 1'b1;
    #1 d = bus.io_read_data;
    @(posedge clk);
    #1 bus.io_read_en = 1'b0;
  endtask
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.io_address = a;
    bus.io_write_data = d;
    bus.io_write_en = 1'b1;
    @(posedge clk);
    #1 bus.io_write_en = 1'b0;
  endtask
  task automatic m_push(input logic [7:0] b);
    if (q.size() == FL) m_ovr = 1'b1;
    else q.push_back(b);
  endtask
  task automatic rd_status(input string tag);
    logic [31:0] g;
    bus_rd(ST_A, g);
    chk(tag, g, {28'h0, m_fe, m_ovr, 1'b1, q.size() != 0});
    m_ovr = 1'b0;
    m_fe = 1'b0;
  endtask
  task automatic rd_rx(input string tag);
    logic [31:0] g, e;
    e = q.size() != 0 ? {24'h0, q.pop_front()} : 32'h0;
    bus_rd(RX_A, g);
    chk(tag, g, e);
  endtask
  task automatic wait_start(output bit ok);
    int t = 0;
    do begin @(negedge clk); t++; end while (uart_tx && t < 8);
    ok = !uart_tx;
    chk("tx_start_seen", {31'h0, ok}, 32'h1);
  endtask
  // Drives one 8N1 frame (32 clocks/bit) plus 48 idle clocks, phase-aligned to even cycles.
  // rd_at >= 0 issues an rx-data read on that cycle; otherwise the first cycle rx_ready shows is reported.
  task automatic rx_frame(input logic [7:0] b, input bit ok, input int rd_at, output int rdy_k, output logic [31:0] rd_got);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    rdy_k = -1;
    rd_got = '0;
    @(negedge clk);
    while (cyc % 2 != 0) @(negedge clk);
    for (int k = 0; k < 368; k++) begin
      @(negedge clk);
      bus.io_read_en = 1'b0;
      bus.io_address = ST_A;
      uart_rx = (k < 288) ? fr[k/32] : (ok || k >= 312);
      if (k == rd_at) begin
        bus.io_address = RX_A;
        bus.io_read_en = 1'b1;
        #1 rd_got = bus.io_read_data;
      end else begin
        #1;
        if (rdy_k < 0 && bus.io_read_data[0]) rdy_k = k;
      end
    end
    bus.io_read_en = 1'b0;
  endtask
  task automatic tx_frame(input logic [31:0] w);
    logic [9:0] fr;
    bit ok;
    fr = {1'b1, w[7:0], 1'b0};
    bus_wr(TX_A, w);
    wait_start(ok);
    for (int k = 0; k <= 320 && ok; k++) begin
      if (k != 0) @(negedge clk);
      bus.io_write_en = 1'b0;
      bus.io_address = ST_A;
      #1;
      if (k % 32 == 16) chk("tx_bit", uart_tx, fr[k/32]);
      if (k == 40 || k == 319 || k == 320) chk("tx_ready", bus.io_read_data[1], k == 320);
      if (k == 100) begin
        bus.io_address = TX_A;
        bus.io_write_data = ~w;
        bus.io_write_en = 1'b1;
      end
    end
    bus.io_write_en = 1'b0;
  endtask
  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int rdy, dummy;
    logic [31:0] g, w;
    logic [7:0] b;
    bit ok;
    bus.io_address = '0;
    bus.io_read_en = 1'b0;
    bus.io_write_en = 1'b0;
    bus.io_write_data = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_tx", uart_tx, 1'b1);
    rd_status("reset_status");
    rd_rx("reset_rx_empty");
    tx_frame(32'h1A5);
    for (int i = 0; i < 2; i++) begin
      w = $urandom();
      tx_frame(w);
    end
    rx_frame(8'h3C, 1'b1, -1, rdy, g);
    m_push(8'h3C);
    rd_status("rx1_status");
    rd_rx("rx1_data");
    rd_status("rx1_status_after");
    for (int i = 0; i < 9; i++) begin
      rx_frame(8'(i), 1'b1, -1, dummy, g);
      m_push(8'(i));
    end
    rd_status("ovr_status");
    rd_status("ovr_cleared");
    for (int i = 0; i < 9; i++) rd_rx("ovr_data");
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    rd_status("glitch_status");
    rx_frame(8'h55, 1'b0, -1, dummy, g);
    m_fe = 1'b1;
    rd_status("ferr_status");
    rd_rx("ferr_rx_empty");
    b = 8'($urandom());
    rx_frame(b, 1'b1, -1, rdy, g);
    m_push(b);
    chk("calib_found", {31'h0, rdy > 0}, 32'h1);
    rd_rx("calib_data");
    for (int i = 0; i < FL; i++) begin
      b = 8'($urandom());
      rx_frame(b, 1'b1, -1, dummy, g);
      m_push(b);
    end
    b = 8'($urandom());
    rx_frame(b, 1'b1, rdy - 1, dummy, g);
    chk("fullpop_data", g, {24'h0, q.pop_front()});
    m_push(b);
    rd_status("fullpop_status");
    for (int i = 0; i < FL + 1; i++) rd_rx("fullpop_drain");
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          b = 8'($urandom());
          ok = $urandom_range(0, 7) != 0;
          rx_frame(b, ok, -1, dummy, g);
          if (ok) m_push(b);
          else m_fe = 1'b1;
        end
        3: rd_status("rand_status");
        default: rd_rx("rand_rx");
      endcase
    end
    b = 8'($urandom());
    rx_frame(b, 1'b1, -1, dummy, g);
    w = $urandom();
    w[4] = 1'b0;
    bus_wr(TX_A, w);
    wait_start(ok);
    repeat (176) @(negedge clk);
    bus.io_address = ST_A;
    #1 chk("rst_pre_bit4", uart_tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_tx_high", uart_tx, 1'b1);
    chk("rst_status", bus.io_read_data, 32'h2);
    reset = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    rd_rx("rst_rx_empty");
    rd_status("rst_status_after");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
